// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and launch sequencer feeding a UART transmitter
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_ovf,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     start,
  output logic [DATA_W-1:0]        tx_data_in,
  input  logic                     tx_active,
  input  logic                     done_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);

  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty && !tx_active;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;
    end
  end

  // done_tx is only honoured in WAIT_DONE; strays elsewhere fall through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start      <= 1'b0;
      tx_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          start <= 1'b0;
          if (pop) begin
            tx_data_in <= mem[rd_ptr];
            start      <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          start <= 1'b0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          start <= 1'b0;
          if (done_tx) state <= IDLE;
        end
        default: begin
          start <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       start;
  logic [7:0] tx_data_in;
  logic       tx_active;
  logic       done_tx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_feeder #(.DEPTH(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy),
    .start(start), .tx_data_in(tx_data_in), .tx_active(tx_active), .done_tx(done_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_done();
    done_tx = 1'b1;
    tick();
    done_tx = 1'b0;
  endtask

  // Waits (bounded) for each launch, checks the byte, then completes the frame.
  task automatic drain_expect(input int n, input logic [7:0] first);
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      int cyc;
      cyc = 0;
      exp = first + i[7:0];
      while (start !== 1'b1 && cyc < 10) begin
        tick();
        cyc++;
      end
      n_checks++;
      if (start !== 1'b1 || tx_data_in !== exp) begin
        n_fail++;
        $display("FAIL drain[%0d]: start=%b tx_data_in=%02h, required start=1 tx_data_in=%02h",
                 i, start, tx_data_in, exp);
      end
      tick();
      pulse_done();
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({start, tx_data_in, count, empty, full, overflow, busy} !== {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: start=%b data=%02h count=%0d empty=%b full=%b ovf=%b busy=%b, required 0 00 0 1 0 0 0",
               start, tx_data_in, count, empty, full, overflow, busy);
    end
  endtask

  task automatic test_single_byte();
    write_byte(8'hA5);
    n_checks++;
    if (count !== 5'd1 || empty !== 1'b0 || start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write: count=%0d empty=%b start=%b, required 1 0 0", count, empty, start);
    end
    tick();
    n_checks++;
    if (start !== 1'b1 || tx_data_in !== 8'hA5 || count !== 5'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_launch: start=%b data=%02h count=%0d busy=%b, required 1 a5 0 1",
               start, tx_data_in, count, busy);
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (start !== 1'b0 || busy !== 1'b1 || tx_data_in !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_wait: start=%b busy=%b data=%02h, required 0 1 a5", start, busy, tx_data_in);
    end
    pulse_done();
    tick();
    n_checks++;
    if (busy !== 1'b0 || start !== 1'b0 || tx_data_in !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_done: busy=%b start=%b data=%02h, required 0 0 a5", busy, start, tx_data_in);
    end
  endtask

  task automatic test_burst_overflow();
    write_byte(8'hEE);
    tick();
    for (int i = 0; i < 16; i++) write_byte(i[7:0]);
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_full: full=%b count=%0d ovf=%b, required 1 16 0", full, count, overflow);
    end
    write_byte(8'hFF);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL burst_ovf: ovf=%b count=%0d, required 1 16", overflow, count);
    end
    clr_ovf = 1'b1;
    write_byte(8'hFF);
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf=%b, required 1", overflow);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b, required 0", overflow);
    end
    pulse_done();
    tick();
    n_checks++;
    if (start !== 1'b1 || tx_data_in !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_latency: start=%b data=%02h, required 1 00", start, tx_data_in);
    end
    tick();
    n_checks++;
    if (start !== 1'b0) begin
      n_fail++;
      $display("FAIL start_width: start=%b, required 0", start);
    end
    pulse_done();
    drain_expect(15, 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (start !== 1'b0 || empty !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_no_ff: start=%b empty=%b, required 0 1", start, empty);
      end
    end
  endtask

  task automatic test_concurrent_and_gating();
    tx_active = 1'b1;
    write_byte(8'h10);
    write_byte(8'h11);
    write_byte(8'h12);
    tick();
    tick();
    n_checks++;
    if (count !== 5'd3 || start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_hold: count=%0d start=%b busy=%b, required 3 0 0", count, start, busy);
    end
    tx_active = 1'b0;
    write_byte(8'h13);
    n_checks++;
    if (count !== 5'd3 || start !== 1'b1 || tx_data_in !== 8'h10) begin
      n_fail++;
      $display("FAIL push_pop: count=%0d start=%b data=%02h, required 3 1 10", count, start, tx_data_in);
    end
    tick();
    pulse_done();
    drain_expect(3, 8'h11);
  endtask

  task automatic test_wrap();
    for (int b = 0; b < 5; b++) begin
      logic [7:0] base;
      base = 8'h40 + 8'(b * 8);
      tx_active = 1'b1;
      for (int i = 0; i < 8; i++) write_byte(base + i[7:0]);
      tx_active = 1'b0;
      drain_expect(8, base);
    end
    n_checks++;
    if (empty !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end: empty=%b busy=%b, required 1 0", empty, busy);
    end
  endtask

  task automatic test_stray_done();
    pulse_done();
    n_checks++;
    if (busy !== 1'b0 || start !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_idle: busy=%b start=%b, required 0 0", busy, start);
    end
    tx_active = 1'b1;
    write_byte(8'h77);
    tx_active = 1'b0;
    tick();
    done_tx = 1'b1;
    tick();
    done_tx = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || start !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_launch: busy=%b start=%b, required 1 0", busy, start);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_launch_hold: busy=%b, required 1", busy);
    end
    pulse_done();
  endtask

  task automatic test_reset_mid_frame();
    write_byte(8'h30);
    tick();
    for (int i = 0; i < 5; i++) write_byte(8'h31 + i[7:0]);
    n_checks++;
    if (count !== 5'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: count=%0d busy=%b, required 5 1", count, busy);
    end
    #3 rst = 1'b0;
    #1;
    test_reset();
    #1 rst = 1'b1;
    tick();
    pulse_done();
    tick();
    n_checks++;
    if (start !== 1'b0 || busy !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL post_reset_done: start=%b busy=%b count=%0d, required 0 0 0", start, busy, count);
    end
    write_byte(8'h5A);
    tick();
    n_checks++;
    if (start !== 1'b1 || tx_data_in !== 8'h5A) begin
      n_fail++;
      $display("FAIL post_reset_launch: start=%b data=%02h, required 1 5a", start, tx_data_in);
    end
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    clr_ovf   = 1'b0;
    tx_active = 1'b0;
    done_tx   = 1'b0;
    #2 rst = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_single_byte();
    test_burst_overflow();
    test_concurrent_and_gating();
    test_wrap();
    test_stray_done();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
